sipo_rx: RTL and testbench

Serial-in/parallel-out receiver: the far end of the team's PISO serial link. It samples one bit per enabled clock, assembles WIDTH-bit words, and presents each completed word on a held parallel output with a valid/ack handshake. It flags words lost to overrun and supports frame realignment through a sync strobe.

---
 rtl/sipo_rx.sv | 105 ++++++++++
 tb/tb_sipo_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from a gated bit
// stream and holds each completed word behind a valid/ack handshake.
module sipo_rx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             sync,
   input  logic             ack,
   input  logic             clr_ovr,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             overrun,
   output logic             busy,
   output logic [CW-1:0]    bit_cnt
);

   // state | meaning
   // IDLE  | no partial frame; next enabled bit starts a frame
   // SHIFT | partial frame in progress, bit_cnt bits collected

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n, base, shifted, dout_n;
   logic [CW-1:0]    cnt_n, cnt_inc;
   logic             first, done, valid_n, set_ovr, ovr_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sreg    <= '0;
         bit_cnt <= '0;
         dout    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         sreg    <= sreg_n;
         bit_cnt <= cnt_n;
         dout    <= dout_n;
         valid   <= valid_n;
         overrun <= ovr_n;
      end
   end

   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = bit_cnt;
      done    = 1'b0;
      // A sync strobe or an idle receiver makes this bit the first of a frame.
      first   = sync || (state == IDLE);
      base    = first ? '0 : sreg;
      cnt_inc = first ? CW'(1) : bit_cnt + CW'(1);
      if (MSB_FIRST)
         shifted = {base[WIDTH-2:0], din};
      else
         shifted = {din, base[WIDTH-1:1]};

      if (sync && !en) begin
         state_n = IDLE;
         sreg_n  = '0;
         cnt_n   = '0;
      end else if (en) begin
         if (cnt_inc == CNT_LAST) begin
            done    = 1'b1;
            state_n = IDLE;
            sreg_n  = '0;
            cnt_n   = '0;
         end else begin
            state_n = SHIFT;
            sreg_n  = shifted;
            cnt_n   = cnt_inc;
         end
      end
   end

   always_comb begin
      dout_n  = dout;
      valid_n = valid;
      set_ovr = 1'b0;
      if (done) begin
         if (!valid || ack) begin
            dout_n  = shifted;
            valid_n = 1'b1;
         end else begin
            set_ovr = 1'b1;
         end
      end else if (valid && ack) begin
         valid_n = 1'b0;
      end
      // A fresh overrun outranks a simultaneous clear.
      ovr_n = set_ovr | (overrun & ~clr_ovr);
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: an MSB-first and an LSB-first instance share stimulus.
module tb_sipo_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0, en = 1'b0, din = 1'b0, sync = 1'b0, ack = 1'b0, clr_ovr = 1'b0;
   logic [3:0] dm, dl;
   logic       vm, vl, om, ol, bm, bl;
   logic [2:0] cm, cl;
   int         tests = 0;
   int         fails = 0;

   sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync), .ack(ack), .clr_ovr(clr_ovr),
      .dout(dm), .valid(vm), .overrun(om), .busy(bm), .bit_cnt(cm));

   sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync), .ack(ack), .clr_ovr(clr_ovr),
      .dout(dl), .valid(vl), .overrun(ol), .busy(bl), .bit_cnt(cl));

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic b);
      en  = 1'b1;
      din = b;
      tick();
      en  = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b1; din = 1'b1; ack = 1'b1; sync = 1'b1; clr_ovr = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0; din = 1'b0; ack = 1'b0; sync = 1'b0;
      tests++;
      if ({dm, vm, om, bm, cm} !== 10'b0) begin
         fails++;
         $display("FAIL reset_msb got dout=%b valid=%b ovr=%b busy=%b cnt=%0d, all zero required", dm, vm, om, bm, cm);
      end
      tests++;
      if ({dl, vl, ol, bl, cl} !== 10'b0) begin
         fails++;
         $display("FAIL reset_lsb got dout=%b valid=%b ovr=%b busy=%b cnt=%0d, all zero required", dl, vl, ol, bl, cl);
      end
   endtask

   task automatic test_msb_basic();
      logic [3:0] bits;
      logic [2:0] cnt_exp [4];
      bits = 4'b1010;
      cnt_exp = '{3'd1, 3'd2, 3'd3, 3'd0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(bits[3-i]);
         tests++;
         if (cm !== cnt_exp[i]) begin
            fails++;
            $display("FAIL msb_bit_cnt[%0d] got %0d exp %0d", i, cm, cnt_exp[i]);
         end
         if (i == 0) begin
            tests++;
            if (bm !== 1'b1 || vm !== 1'b0) begin
               fails++;
               $display("FAIL msb_first_bit got busy=%b valid=%b exp busy=1 valid=0", bm, vm);
            end
         end
      end
      tests++;
      if (dm !== 4'b1010 || vm !== 1'b1 || om !== 1'b0 || bm !== 1'b0) begin
         fails++;
         $display("FAIL msb_word got dout=%b valid=%b ovr=%b busy=%b exp 1010 1 0 0", dm, vm, om, bm);
      end
   endtask

   task automatic test_lsb_gaps();
      logic [3:0] bits;
      bits = 4'b1100;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(bits[3-i]);
         if (i < 3) begin
            tick();
            tick();
            tests++;
            if (cl !== 3'(i + 1) || bl !== 1'b1) begin
               fails++;
               $display("FAIL lsb_gap_hold[%0d] got cnt=%0d busy=%b exp cnt=%0d busy=1", i, cl, bl, i + 1);
            end
         end
      end
      tests++;
      if (dl !== 4'b0011 || vl !== 1'b1 || ol !== 1'b0) begin
         fails++;
         $display("FAIL lsb_word got dout=%b valid=%b ovr=%b exp 0011 1 0", dl, vl, ol);
      end
      tests++;
      if (dm !== 4'b1100 || vm !== 1'b1) begin
         fails++;
         $display("FAIL msb_gap_word got dout=%b valid=%b exp 1100 1", dm, vm);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      send(1); send(0); send(1); send(0);
      send(1); send(1); send(0); send(0);
      tests++;
      if (dm !== 4'b1010 || vm !== 1'b1 || om !== 1'b1) begin
         fails++;
         $display("FAIL overrun_drop got dout=%b valid=%b ovr=%b exp 1010 1 1", dm, vm, om);
      end
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      tests++;
      if (om !== 1'b0 || vm !== 1'b1 || dm !== 4'b1010) begin
         fails++;
         $display("FAIL overrun_clear got ovr=%b valid=%b dout=%b exp 0 1 1010", om, vm, dm);
      end
      send(1); send(1); send(0);
      ack = 1'b1;
      send(0);
      ack = 1'b0;
      tests++;
      if (dm !== 4'b1100 || vm !== 1'b1 || om !== 1'b0) begin
         fails++;
         $display("FAIL ack_on_complete got dout=%b valid=%b ovr=%b exp 1100 1 0", dm, vm, om);
      end
      send(0); send(1); send(1);
      clr_ovr = 1'b1;
      send(0);
      clr_ovr = 1'b0;
      tests++;
      if (om !== 1'b1 || dm !== 4'b1100) begin
         fails++;
         $display("FAIL set_beats_clear got ovr=%b dout=%b exp 1 1100", om, dm);
      end
   endtask

   task automatic test_sync();
      do_reset();
      send(1);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      tests++;
      if (cm !== 3'd0 || bm !== 1'b0) begin
         fails++;
         $display("FAIL sync_idle got cnt=%0d busy=%b exp 0 0", cm, bm);
      end
      send(1); send(1);
      sync = 1'b1;
      send(0);
      sync = 1'b0;
      tests++;
      if (cm !== 3'd1 || bm !== 1'b1) begin
         fails++;
         $display("FAIL sync_first_bit got cnt=%0d busy=%b exp 1 1", cm, bm);
      end
      send(0); send(1); send(1);
      tests++;
      if (dm !== 4'b0011 || vm !== 1'b1 || om !== 1'b0) begin
         fails++;
         $display("FAIL sync_word got dout=%b valid=%b ovr=%b exp 0011 1 0", dm, vm, om);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(1); send(1); send(1); send(1);
      send(1); send(0); send(1);
      en = 1'b1; din = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0;
      tests++;
      if ({dm, vm, om, bm, cm} !== 10'b0) begin
         fails++;
         $display("FAIL reset_mid got dout=%b valid=%b ovr=%b busy=%b cnt=%0d, all zero required", dm, vm, om, bm, cm);
      end
      send(0); send(1); send(1); send(0);
      tests++;
      if (dm !== 4'b0110 || vm !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_word got dout=%b valid=%b exp 0110 1", dm, vm);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] stream;
      int         got;
      logic [3:0] exp_w [2];
      stream = 8'b1010_0101;
      exp_w  = '{4'b1010, 4'b0101};
      got    = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         ack = vm;
         en  = (i < 8);
         din = (i < 8) ? stream[7-i] : 1'b0;
         tick();
         if (vm && !ack && got < 2 && (i == 3 || i == 7)) begin
            tests++;
            if (dm !== exp_w[got]) begin
               fails++;
               $display("FAIL b2b_word[%0d] got %b exp %b", got, dm, exp_w[got]);
            end
            got++;
         end
      end
      en = 1'b0; ack = 1'b0;
      tests++;
      if (got !== 2 || om !== 1'b0 || vm !== 1'b0) begin
         fails++;
         $display("FAIL b2b_summary got words=%0d ovr=%b valid=%b exp 2 0 0", got, om, vm);
      end
   endtask

   initial begin
      test_reset();
      test_msb_basic();
      test_lsb_gaps();
      test_overrun();
      test_sync();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
